op_uart_ctrl: RTL and testbench
===============================

Name: op_uart_ctrl

Overview:
- CSR-mapped 8N1 UART: 16x-oversampled receiver and transmitter, programmable baud divisor, one-cycle RX/TX interrupt pulses, and a "thru" pass-through mode.
- The system-side host writes bytes through the CSR bus.
- The serial side connects to the program-loader UART of the fwrisc FPGA top, which receives program images over serial.

Parameters:
- CSR_ADDR, 4'h0: bank ID. The block responds only when csr_a[13:10] == CSR_ADDR.
- CLK_FREQ, 100000000: sys_clk frequency in Hz.
- BAUD, 115200: reset baud rate. Reset divisor = CLK_FREQ/(16*BAUD), i.e. 54.

Ports:
- sys_clk  input  1  system clock; all logic is rising-edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- csr_a  input  14  CSR address. [13:10] = bank, [1:0] = register, [9:2] ignored.
- csr_we  input  1  write strobe, sampled on a rising edge.
- csr_di  input  32  write data.
- csr_do  output  32  read data, registered.
- rx_irq  output  1  one-cycle pulse when a valid byte has been received.
- tx_irq  output  1  one-cycle pulse when a transmission completes.
- uart_rx  input  1  serial input, idle high.
- uart_tx  output  1  serial output, idle high.

Behaviour:
- Reset (asynchronous on sys_rst_n low) sets:
  - uart_tx=1, csr_do=0, rx_irq=0, tx_irq=0;
  - thru=0, divisor=54, tx_busy=0, rx_data=0;
  - rx/tx FSMs to IDLE.
- Register map (csr_a[1:0]):
  - 00 RXTX: write loads a TX byte from csr_di[7:0]; read returns the last received byte.
  - 01 DIVISOR: [15:0] read/write.
  - 10 CTRL: bit0 = thru, read/write.
  - 11 STAT: read-only; bit0 = tx_busy, bit1 = rx_avail. rx_avail sets on rx_irq and clears on a read of RXTX.
- CSR access:
  - Writes take effect on the rising edge where csr_we=1 and the bank matches.
  - csr_do updates every cycle: selected register value if the bank matches, else 0. Read latency is one cycle.
  - Unused bits read 0.
- Baud tick:
  - A 16-bit counter counts down from divisor-1; one cycle at 0 is one tick, i.e. 16 ticks per bit.
  - Divisor 0 is treated as 1.
  - Writing DIVISOR reloads the counter immediately.
- TX FSM (IDLE, START, DATA, STOP):
  - A RXTX write in IDLE latches the byte, sets tx_busy, and drives the start bit (0) on the next tick boundary.
  - Frame: 8 data bits LSB first, then stop bit (1); each bit lasts 16 ticks.
  - At the end of the stop bit: tx_busy=0, tx_irq pulses for one cycle, FSM returns to IDLE.
  - A RXTX write while tx_busy=1 is dropped silently.
- RX FSM (IDLE, START, DATA, STOP):
  - uart_rx passes through a 2-flop synchronizer.
  - IDLE: a low level starts the frame.
  - START: the line is resampled after 8 ticks (mid-bit); if high, it was a glitch and the FSM returns to IDLE.
  - DATA: bits are sampled every 16 ticks at mid-bit, LSB first.
  - STOP: sampled at mid stop bit. If 1: rx_data updates, rx_irq pulses one cycle, rx_avail=1. If 0 (framing error): byte discarded, no irq.
  - After the stop sample, return to IDLE and wait for the line to be high before accepting a new start bit.
  - A new byte overwrites an unread rx_data.
- thru=1:
  - uart_tx = synchronized uart_rx, i.e. 2-cycle delay.
  - The TX FSM still runs and raises tx_irq, but its output is masked.
  - The RX path is unaffected.
  - thru=0 selects the TX shift output.
- Simultaneous events: a CSR write and an FSM update of the same state in one cycle resolve with the FSM event first, then the write. Example: rx_irq and a RXTX read in the same cycle leave rx_avail=1.

Decomposition:
- Shared package op_uart_pkg holds the register offsets (REG_RXTX=2'b00, REG_DIV=2'b01, REG_CTRL=2'b10, REG_STAT=2'b11), the TX/RX state enums, and the default-divisor function.
- One sub-module, op_uart_transceiver, contains the baud generator, RX/TX FSMs, and irq pulses.
- The top-level op_uart_ctrl holds the CSR decode, registers, and thru mux.

Test Plan:
- Reset: hold sys_rst_n=0 → uart_tx=1, irqs=0, csr_do=0. Read DIVISOR → 54. Read CTRL → 0.
- TX frame: write DIV=1, then RXTX=0xA5 → uart_tx goes 0, then 1,0,1,0,0,1,0,1 (LSB first), then 1, each bit 16 cycles. tx_irq pulses once 160 cycles after the start. STAT bit0 is 1 during the frame.
- Loopback RX: tie uart_tx to uart_rx, write 0x3C → rx_irq pulses once. STAT reads 0x2. RXTX read returns 0x3C. STAT then reads 0.
- Busy and bank: write 0x11, then 0x22 while busy → only 0x11 is transmitted. A write with csr_a[13:10]=4'h1 has no effect, and reads in that bank return 0.
- Thru and framing: CTRL=1, toggle uart_rx → uart_tx follows with 2-cycle delay. An RX frame with stop bit 0 produces no rx_irq and leaves rx_data unchanged.
- Reset mid-frame: assert sys_rst_n during a TX data bit → uart_tx=1 immediately, tx_busy=0, and the next write transmits a clean frame.

Source files
------------

// File: rtl/op_uart_pkg.sv
// Shared definitions for the CSR-mapped 8N1 UART: register offsets, FSM
// state encodings and the reset baud divisor.
package op_uart_pkg;

  localparam logic [1:0] REG_RXTX = 2'b00;
  localparam logic [1:0] REG_DIV  = 2'b01;
  localparam logic [1:0] REG_CTRL = 2'b10;
  localparam logic [1:0] REG_STAT = 2'b11;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic [15:0] default_divisor(input int unsigned clk_freq,
                                                  input int unsigned baud);
    int unsigned div;
    div = clk_freq / (16 * baud);
    return div[15:0];
  endfunction

endpackage

// File: rtl/op_uart_transceiver.sv
// Baud tick generator, 16x-oversampled RX/TX state machines and irq pulses.
//   state    | meaning
//   IDLE     | TX: waiting for a byte / first tick; RX: waiting for armed low level
//   START    | start bit (TX drives 0 for 16 ticks; RX resamples after 8 ticks)
//   DATA     | 8 data bits, LSB first, 16 ticks each
//   STOP     | stop bit; completion raises the one-cycle irq
module op_uart_transceiver (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] divisor,
  input  logic        div_load,
  input  logic [15:0] div_load_value,
  input  logic        tx_start,
  input  logic [7:0]  tx_byte,
  input  logic        uart_rx,
  output logic        rx_sync,
  output logic        tx_out,
  output logic        tx_busy,
  output logic        tx_irq,
  output logic        rx_irq,
  output logic [7:0]  rx_data
);
  import op_uart_pkg::*;

  logic [15:0] baud_cnt;
  logic [15:0] div_eff;
  logic [15:0] load_eff;
  logic        tick;
  logic        rx_s1;

  // A zero divisor behaves like one so the tick never stalls.
  assign div_eff  = (divisor == 16'd0) ? 16'd1 : divisor;
  assign load_eff = (div_load_value == 16'd0) ? 16'd1 : div_load_value;
  assign tick     = (baud_cnt == 16'd0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)    baud_cnt <= 16'd0;
    else if (div_load) baud_cnt <= load_eff - 16'd1;
    else if (tick)     baud_cnt <= div_eff - 16'd1;
    else               baud_cnt <= baud_cnt - 16'd1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_sync <= rx_s1;
    end
  end

  tx_state_t  tx_state;
  logic       tx_pend;
  logic [7:0] tx_shift;
  logic [3:0] tx_tcnt;
  logic [2:0] tx_bcnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state <= TX_IDLE;
      tx_pend  <= 1'b0;
      tx_shift <= 8'd0;
      tx_tcnt  <= 4'd0;
      tx_bcnt  <= 3'd0;
      tx_out   <= 1'b1;
      tx_busy  <= 1'b0;
      tx_irq   <= 1'b0;
    end else begin
      tx_irq <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          // The start bit is aligned to the next tick boundary after the write.
          if (tx_pend) begin
            if (tick) begin
              tx_pend  <= 1'b0;
              tx_out   <= 1'b0;
              tx_tcnt  <= 4'd15;
              tx_state <= TX_START;
            end
          end else if (tx_start) begin
            tx_pend  <= 1'b1;
            tx_busy  <= 1'b1;
            tx_shift <= tx_byte;
          end
        end
        TX_START: if (tick) begin
          if (tx_tcnt == 4'd0) begin
            tx_out   <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bcnt  <= 3'd7;
            tx_tcnt  <= 4'd15;
            tx_state <= TX_DATA;
          end else tx_tcnt <= tx_tcnt - 4'd1;
        end
        TX_DATA: if (tick) begin
          if (tx_tcnt == 4'd0) begin
            tx_tcnt <= 4'd15;
            if (tx_bcnt == 3'd0) begin
              tx_out   <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_out   <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bcnt  <= tx_bcnt - 3'd1;
            end
          end else tx_tcnt <= tx_tcnt - 4'd1;
        end
        TX_STOP: if (tick) begin
          if (tx_tcnt == 4'd0) begin
            tx_busy  <= 1'b0;
            tx_irq   <= 1'b1;
            tx_state <= TX_IDLE;
          end else tx_tcnt <= tx_tcnt - 4'd1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  rx_state_t  rx_state;
  logic       rx_armed;
  logic [7:0] rx_shift;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bcnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state <= RX_IDLE;
      rx_armed <= 1'b0;
      rx_shift <= 8'd0;
      rx_tcnt  <= 4'd0;
      rx_bcnt  <= 3'd0;
      rx_data  <= 8'd0;
      rx_irq   <= 1'b0;
    end else begin
      rx_irq <= 1'b0;
      case (rx_state)
        // Armed only after the line has been seen high, so a stuck-low line
        // after a framing error cannot retrigger a frame.
        RX_IDLE: begin
          if (rx_sync) rx_armed <= 1'b1;
          else if (rx_armed) begin
            rx_armed <= 1'b0;
            rx_tcnt  <= 4'd7;
            rx_state <= RX_START;
          end
        end
        RX_START: if (tick) begin
          if (rx_tcnt == 4'd0) begin
            if (rx_sync) rx_state <= RX_IDLE;
            else begin
              rx_tcnt  <= 4'd15;
              rx_bcnt  <= 3'd7;
              rx_state <= RX_DATA;
            end
          end else rx_tcnt <= rx_tcnt - 4'd1;
        end
        RX_DATA: if (tick) begin
          if (rx_tcnt == 4'd0) begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_tcnt  <= 4'd15;
            if (rx_bcnt == 3'd0) rx_state <= RX_STOP;
            else rx_bcnt <= rx_bcnt - 3'd1;
          end else rx_tcnt <= rx_tcnt - 4'd1;
        end
        RX_STOP: if (tick) begin
          if (rx_tcnt == 4'd0) begin
            if (rx_sync) begin
              rx_data <= rx_shift;
              rx_irq  <= 1'b1;
            end
            rx_state <= RX_IDLE;
          end else rx_tcnt <= rx_tcnt - 4'd1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/op_uart_ctrl.sv
// CSR front end for the UART: bank/register decode, DIVISOR/CTRL/STAT
// registers, registered read port and the thru output mux.
module op_uart_ctrl #(
  parameter logic [3:0]  CSR_ADDR = 4'h0,
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        rx_irq,
  output logic        tx_irq,
  input  logic        uart_rx,
  output logic        uart_tx
);
  import op_uart_pkg::*;

  localparam logic [15:0] DIV_RST = default_divisor(CLK_FREQ, BAUD);

  logic        bank_hit, wr, rd_rxtx;
  logic [1:0]  sel;
  logic        thru, rx_avail, tx_busy, tx_out, rx_sync;
  logic [15:0] divisor;
  logic [7:0]  rx_data;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign bank_hit    = (csr_a[13:10] == CSR_ADDR);
  assign sel         = csr_a[1:0];
  assign wr          = csr_we & bank_hit;
  assign rd_rxtx     = bank_hit & ~csr_we & (sel == REG_RXTX);
  assign unused_bits = ^{csr_a[9:2], csr_di[31:16]};

  always_comb begin
    rd_val = 32'd0;
    if (bank_hit) begin
      case (sel)
        REG_RXTX: rd_val = {24'd0, rx_data};
        REG_DIV:  rd_val = {16'd0, divisor};
        REG_CTRL: rd_val = {31'd0, thru};
        REG_STAT: rd_val = {30'd0, rx_avail, tx_busy};
        default:  rd_val = 32'd0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      thru     <= 1'b0;
      divisor  <= DIV_RST;
      rx_avail <= 1'b0;
      csr_do   <= 32'd0;
    end else begin
      csr_do <= rd_val;
      if (wr && sel == REG_DIV)  divisor <= csr_di[15:0];
      if (wr && sel == REG_CTRL) thru    <= csr_di[0];
      // A byte arriving in the same cycle as the RXTX read wins.
      if (rx_irq)       rx_avail <= 1'b1;
      else if (rd_rxtx) rx_avail <= 1'b0;
    end
  end

  op_uart_transceiver u_xcvr (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .divisor        (divisor),
    .div_load       (wr && sel == REG_DIV),
    .div_load_value (csr_di[15:0]),
    .tx_start       (wr && sel == REG_RXTX),
    .tx_byte        (csr_di[7:0]),
    .uart_rx        (uart_rx),
    .rx_sync        (rx_sync),
    .tx_out         (tx_out),
    .tx_busy        (tx_busy),
    .tx_irq         (tx_irq),
    .rx_irq         (rx_irq),
    .rx_data        (rx_data)
  );

  assign uart_tx = thru ? rx_sync : tx_out;

endmodule

// File: tb/tb_op_uart_ctrl.sv
// Directed bench for op_uart_ctrl: CSR access, TX framing, loopback RX,
// busy/bank filtering, thru mode, framing errors and reset mid-frame.
module tb_op_uart_ctrl;

  localparam logic [13:0] A_IDLE    = 14'h3C00;
  localparam logic [13:0] A_RXTX    = 14'h0000;
  localparam logic [13:0] A_DIV     = 14'h0001;
  localparam logic [13:0] A_CTRL    = 14'h0002;
  localparam logic [13:0] A_STAT    = 14'h0003;
  localparam logic [13:0] A_B1_RXTX = 14'h0400;
  localparam logic [13:0] A_B1_DIV  = 14'h0401;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [13:0] csr_a = A_IDLE;
  logic        csr_we = 1'b0;
  logic [31:0] csr_di = 32'd0;
  logic [31:0] csr_do;
  logic        rx_irq, tx_irq, uart_tx, uart_rx;
  logic        rx_drv = 1'b1;
  logic        loop_en = 1'b0;

  int checks = 0, errors = 0;
  int cyc = 0, tx_irq_cnt = 0, rx_irq_cnt = 0, tx_irq_cyc = 0;

  assign uart_rx = loop_en ? uart_tx : rx_drv;

  op_uart_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .rx_irq    (rx_irq),
    .tx_irq    (tx_irq),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;
  always @(negedge sys_clk) begin
    if (tx_irq) begin
      tx_irq_cnt++;
      tx_irq_cyc = cyc;
    end
    if (rx_irq) rx_irq_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    step(1);
    csr_we = 1'b0; csr_a = A_IDLE;
  endtask

  task automatic rd_chk(input string tag, input logic [13:0] a, input logic [31:0] exp);
    csr_a = a;
    step(1);
    chk(tag, csr_do, exp);
    csr_a = A_IDLE;
  endtask

  task automatic wait_tx_low(input int max_cyc);
    for (int i = 0; i < max_cyc && uart_tx !== 1'b0; i++) step(1);
    chk("tx_start_seen", 32'(uart_tx), 32'd0);
  endtask

  task automatic wait_tx_done(input int prev, input int max_cyc);
    for (int i = 0; i < max_cyc && tx_irq_cnt == prev; i++) step(1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx_drv = 1'b0;
    step(16);
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      step(16);
    end
    rx_drv = stop_bit;
    step(16);
    rx_drv = 1'b1;
    step(20);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start_cyc, p_tx, p_rx, lows;
    logic [7:0] pat;

    // reset
    step(3);
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_rx_irq", 32'(rx_irq), 32'd0);
    chk("rst_tx_irq", 32'(tx_irq), 32'd0);
    chk("rst_csr_do", csr_do, 32'd0);
    sys_rst_n = 1'b1;
    step(2);
    rd_chk("rst_div", A_DIV, 32'd54);
    rd_chk("rst_ctrl", A_CTRL, 32'd0);
    rd_chk("rst_stat", A_STAT, 32'd0);

    // TX frame 0xA5 at divisor 1
    wr(A_DIV, 32'd1);
    rd_chk("div_wr", A_DIV, 32'd1);
    p_tx = tx_irq_cnt;
    pat = 8'hA5;
    wr(A_RXTX, 32'h0A5);
    wait_tx_low(50);
    start_cyc = cyc;
    rd_chk("stat_busy", A_STAT, 32'd1);
    step(7);
    chk("tx_startbit", 32'(uart_tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(16);
      chk($sformatf("tx_bit%0d", i), 32'(uart_tx), 32'(pat[i]));
    end
    step(16);
    chk("tx_stopbit", 32'(uart_tx), 32'd1);
    wait_tx_done(p_tx, 40);
    step(3);
    chk("tx_irq_once", 32'(tx_irq_cnt - p_tx), 32'd1);
    chk("tx_irq_delay", 32'(tx_irq_cyc - start_cyc), 32'd160);
    rd_chk("stat_idle", A_STAT, 32'd0);

    // loopback receive
    loop_en = 1'b1;
    p_tx = tx_irq_cnt; p_rx = rx_irq_cnt;
    wr(A_RXTX, 32'h3C);
    wait_tx_done(p_tx, 400);
    step(3);
    chk("lb_rx_irq", 32'(rx_irq_cnt - p_rx), 32'd1);
    rd_chk("lb_stat_avail", A_STAT, 32'd2);
    rd_chk("lb_rxtx", A_RXTX, 32'h3C);
    rd_chk("lb_stat_clr", A_STAT, 32'd0);

    // write while busy is dropped
    p_tx = tx_irq_cnt; p_rx = rx_irq_cnt;
    wr(A_RXTX, 32'h11);
    wr(A_RXTX, 32'h22);
    wait_tx_done(p_tx, 400);
    step(20);
    rd_chk("busy_stat", A_STAT, 32'd2);
    rd_chk("busy_rxtx", A_RXTX, 32'h11);
    chk("busy_tx_cnt", 32'(tx_irq_cnt - p_tx), 32'd1);
    chk("busy_rx_cnt", 32'(rx_irq_cnt - p_rx), 32'd1);

    // foreign bank
    wr(A_B1_RXTX, 32'h55);
    step(30);
    chk("bank_no_tx", 32'(uart_tx), 32'd1);
    rd_chk("bank_stat", A_STAT, 32'd0);
    wr(A_B1_DIV, 32'd7);
    rd_chk("bank_div_kept", A_DIV, 32'd1);
    rd_chk("bank_rd_zero", A_B1_DIV, 32'd0);

    // thru mode
    loop_en = 1'b0; rx_drv = 1'b1;
    step(2);
    wr(A_CTRL, 32'd1);
    rd_chk("ctrl_thru", A_CTRL, 32'd1);
    p_rx = rx_irq_cnt; p_tx = tx_irq_cnt;
    rx_drv = 1'b0;
    step(1); chk("thru_fall_d1", 32'(uart_tx), 32'd1);
    step(1); chk("thru_fall_d2", 32'(uart_tx), 32'd0);
    rx_drv = 1'b1;
    step(1); chk("thru_rise_d1", 32'(uart_tx), 32'd0);
    step(1); chk("thru_rise_d2", 32'(uart_tx), 32'd1);
    wr(A_RXTX, 32'h00);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("thru_tx_masked", 32'(lows), 32'd0);
    chk("thru_tx_irq", 32'(tx_irq_cnt - p_tx), 32'd1);
    chk("glitch_no_rx", 32'(rx_irq_cnt - p_rx), 32'd0);
    wr(A_CTRL, 32'd0);
    rd_chk("ctrl_clr", A_CTRL, 32'd0);

    // framing error, then a good frame
    p_rx = rx_irq_cnt;
    send_frame(8'h5A, 1'b0);
    chk("frm_err_no_irq", 32'(rx_irq_cnt - p_rx), 32'd0);
    rd_chk("frm_err_rxtx", A_RXTX, 32'h11);
    p_rx = rx_irq_cnt;
    send_frame(8'h96, 1'b1);
    chk("frm_ok_irq", 32'(rx_irq_cnt - p_rx), 32'd1);
    rd_chk("frm_ok_rxtx", A_RXTX, 32'h96);

    // reset mid-frame
    wr(A_RXTX, 32'hF0);
    wait_tx_low(50);
    step(24);
    chk("mid_bit0", 32'(uart_tx), 32'd0);
    sys_rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(uart_tx), 32'd1);
    step(2);
    sys_rst_n = 1'b1;
    step(1);
    rd_chk("rst_mid_stat", A_STAT, 32'd0);
    rd_chk("rst_mid_div", A_DIV, 32'd54);
    rd_chk("rst_mid_rxtx", A_RXTX, 32'd0);
    wr(A_DIV, 32'd1);
    loop_en = 1'b1;
    step(2);
    p_tx = tx_irq_cnt; p_rx = rx_irq_cnt;
    wr(A_RXTX, 32'hC3);
    wait_tx_done(p_tx, 400);
    step(5);
    chk("post_rst_tx_irq", 32'(tx_irq_cnt - p_tx), 32'd1);
    chk("post_rst_rx_irq", 32'(rx_irq_cnt - p_rx), 32'd1);
    rd_chk("post_rst_rxtx", A_RXTX, 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
